// File: rtl/uart_pkg.sv
// uart_pkg: types and helpers shared by the UART transmit path and its FIFO users.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int unsigned MIN_DIV = 2;

  // Divisors below two cannot hold a line level for a whole bit, so they are clamped.
  function automatic int unsigned eff_div(input int unsigned div);
    return (div < MIN_DIV) ? MIN_DIV : div;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock first-word-fall-through FIFO; dout is valid while !empty.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "uart_sync_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  // A push is judged against the registered full flag, so a same-cycle pop never frees a slot early.
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (!w_push && w_pop) r_level <= r_level - 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = (r_level == LW'(DEPTH));
  assign empty = (r_level == '0);
  assign level = r_level;

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered UART transmitter with run-time divisor, parity and stop bits.
// Optional line-break input i_break is present when UART_TX_BREAK_EN is defined.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_vld,
  input  logic [DATA_WIDTH-1:0]           i_data,
  output logic                            o_rdy,
  input  logic [DIV_WIDTH-1:0]            cfg_div,
  input  logic [1:0]                      cfg_parity,
  input  logic                            cfg_stop2,
`ifdef UART_TX_BREAK_EN
  input  logic                            i_break,
`endif
  output logic [$clog2(FIFO_DEPTH+1)-1:0] o_level,
  output logic                            o_busy,
  output logic                            tx
);

  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
    $fatal(1, "uart_tx_buffered: DATA_WIDTH must be 5..9");
  end

  localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

  tx_state_e             r_state;
  logic [DIV_WIDTH-1:0]  r_div;
  logic [DIV_WIDTH-1:0]  r_timer;
  logic [3:0]            r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_en;
  logic                  r_parity;
  logic                  r_stop2;
  logic                  r_tx;

  logic [DATA_WIDTH-1:0] w_fifo_dout;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [DIV_WIDTH-1:0]  w_new_div;
  parity_e               w_par_mode;
  logic                  w_bit_end;
  logic                  w_last_stop;
  logic                  w_load;
  logic                  w_block;
  logic                  w_brk_low;
  logic                  w_tx_next;

  uart_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (i_vld),
    .din   (i_data),
    .pop   (w_load),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .level (o_level)
  );

`ifdef UART_TX_BREAK_EN
  logic [DIV_WIDTH-1:0] r_gap;

  // r_gap guarantees a full bit time of idle-high after a break before the next start bit.
  always_ff @(posedge clk) begin
    if (rst)                   r_gap <= '0;
    else if (r_state == IDLE) begin
      if (i_break)             r_gap <= w_new_div;
      else if (r_gap != '0)    r_gap <= r_gap - 1'b1;
    end
  end

  assign w_block   = i_break || (r_gap != '0);
  assign w_brk_low = i_break;
`else
  assign w_block   = 1'b0;
  assign w_brk_low = 1'b0;
`endif

  assign w_new_div   = DIV_WIDTH'(eff_div(32'(cfg_div)));
  assign w_par_mode  = parity_e'(cfg_parity);
  assign w_bit_end   = (r_timer == '0);
  assign w_last_stop = (r_state == STOP) && w_bit_end && (!r_stop2 || r_bit_cnt == 4'd1);
  assign w_load      = !w_fifo_empty && !w_block && ((r_state == IDLE) || w_last_stop);

  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    w_tx_next = 1'b1;
    case (r_state)
      IDLE:    w_tx_next = !w_brk_low;
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = r_shift[0];
      PARITY:  w_tx_next = r_parity;
      default: w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_div     <= DIV_WIDTH'(MIN_DIV);
      r_timer   <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par_en  <= 1'b0;
      r_parity  <= 1'b0;
      r_stop2   <= 1'b0;
      r_tx      <= 1'b1;
    end else begin
      r_tx <= w_tx_next;
      if (w_load) begin
        // Configuration is captured here and held for the whole frame.
        r_state   <= START;
        r_shift   <= w_fifo_dout;
        r_div     <= w_new_div;
        r_timer   <= w_new_div - 1'b1;
        r_bit_cnt <= '0;
        r_stop2   <= cfg_stop2;
        r_par_en  <= (w_par_mode == PAR_ODD) || (w_par_mode == PAR_EVEN);
        r_parity  <= (w_par_mode == PAR_ODD) ? ~^w_fifo_dout : ^w_fifo_dout;
      end else if (r_state != IDLE) begin
        if (!w_bit_end) begin
          r_timer <= r_timer - 1'b1;
        end else begin
          r_timer <= r_div - 1'b1;
          case (r_state)
            START: begin
              r_state   <= DATA;
              r_bit_cnt <= '0;
            end
            DATA: begin
              r_shift <= r_shift >> 1;
              if (r_bit_cnt == LAST_BIT) begin
                r_bit_cnt <= '0;
                r_state   <= r_par_en ? PARITY : STOP;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end
            PARITY: begin
              r_state   <= STOP;
              r_bit_cnt <= '0;
            end
            STOP: begin
              if (w_last_stop) r_state   <= IDLE;
              else             r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            default: r_state <= IDLE;
          endcase
        end
      end
    end
  end

  assign tx     = r_tx;
  assign o_rdy  = !w_fifo_full;
  assign o_busy = (r_state != IDLE) || (o_level != '0);

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: directed and randomized checks of uart_tx_buffered against a frame-level model.
// Define UART_TX_BREAK_EN for both bench and RTL to include the line-break scenario.
module tb_uart_tx_buffered;

  localparam int DW   = 8;
  localparam int FD   = 4;
  localparam int DIVW = 16;
  localparam int LW   = $clog2(FD + 1);

  typedef struct {
    logic [11:0] bits;
    int          nbits;
    int          div;
    bit          contig;
  } frame_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            i_vld = 1'b0;
  logic [DW-1:0]   i_data = '0;
  logic            o_rdy;
  logic [DIVW-1:0] cfg_div = 16'd4;
  logic [1:0]      cfg_parity = 2'd0;
  logic            cfg_stop2 = 1'b0;
  logic            i_break = 1'b0;
  logic [LW-1:0]   o_level;
  logic            o_busy;
  logic            tx;

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     last_end = -10;
  bit     mon_en = 1'b1;
  bit     mon_busy = 1'b0;
  frame_t exp_q[$];

  uart_tx_buffered #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (FD),
    .DIV_WIDTH  (DIVW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_vld      (i_vld),
    .i_data     (i_data),
    .o_rdy      (o_rdy),
    .cfg_div    (cfg_div),
    .cfg_parity (cfg_parity),
    .cfg_stop2  (cfg_stop2),
`ifdef UART_TX_BREAK_EN
    .i_break    (i_break),
`endif
    .o_level    (o_level),
    .o_busy     (o_busy),
    .tx         (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected line levels, one entry per bit time: start, data LSB first, optional parity, stops.
  function automatic frame_t model_frame(input logic [7:0] w, input int div, input int par,
                                         input bit stop2, input bit contig);
    frame_t f;
    int     n;
    int     ones;
    f.bits = '1;
    f.bits[0] = 1'b0;
    for (int i = 0; i < DW; i++) f.bits[1 + i] = w[i];
    n = 1 + DW;
    ones = $countones(w);
    if (par == 1 || par == 2) begin
      f.bits[n] = (par == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
      n++;
    end
    n += stop2 ? 2 : 1;
    f.nbits  = n;
    f.div    = (div < 2) ? 2 : div;
    f.contig = contig;
    return f;
  endfunction

  // Line monitor: every bit of each frame must hold its expected level for exactly div clocks.
  initial begin : monitor
    frame_t f;
    bit     ok;
    int     n;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
          n = 0;
          while (tx === 1'b0 && n < 200) begin @(negedge clk); n++; end
        end else begin
          f = exp_q.pop_front();
          mon_busy = 1'b1;
          if (f.contig) check("frame_gap", cyc - last_end, 32'd1);
          for (int b = 0; b < f.nbits; b++) begin
            ok = 1'b1;
            for (int k = 0; k < f.div; k++) begin
              if (b != 0 || k != 0) @(negedge clk);
              if (tx !== f.bits[b]) ok = 1'b0;
            end
            check($sformatf("frame_bit%0d", b), ok, 32'd1);
          end
          last_end = cyc;
          mon_busy = 1'b0;
        end
      end
    end
  end

  task automatic push_word(input logic [7:0] w, output int stall);
    stall = 0;
    i_vld  = 1'b1;
    i_data = w;
    while (o_rdy !== 1'b1 && stall < 500) begin @(negedge clk); stall++; end
    if (stall >= 500) check("push_timeout", 32'd1, 32'd0);
    @(negedge clk);
    i_vld = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while ((exp_q.size() != 0 || mon_busy) && n < 3000);
    check({tag, "_done"}, n < 3000, 32'd1);
    check({tag, "_busy_low"}, o_busy, 32'd0);
  endtask

  initial begin : stim
    int       stall;
    int       n;
    int       div;
    int       par;
    int       nw;
    bit       stop2;
    bit       tx_low;
    logic [7:0] w;

    repeat (3) @(negedge clk);
    check("rst_tx", tx, 32'd1);
    check("rst_rdy", o_rdy, 32'd1);
    check("rst_level", o_level, 32'd0);
    check("rst_busy", o_busy, 32'd0);
    rst = 1'b0;

    // 0x55, div 4, no parity, one stop: 40-clock frame, start bit two edges after acceptance.
    exp_q.push_back(model_frame(8'h55, 4, 0, 1'b0, 1'b0));
    push_word(8'h55, stall);
    check("t1_level_acc", o_level, 32'd1);
    check("t1_tx_acc", tx, 32'd1);
    @(negedge clk);
    check("t1_tx_e1", tx, 32'd1);
    check("t1_level_pop", o_level, 32'd0);
    check("t1_busy", o_busy, 32'd1);
    @(negedge clk);
    check("t1_tx_start", tx, 32'd0);
    wait_idle("t1");

    // Even then odd parity on 0x55.
    cfg_parity = 2'd2;
    exp_q.push_back(model_frame(8'h55, 4, 2, 1'b0, 1'b0));
    push_word(8'h55, stall);
    wait_idle("t2_even");
    cfg_parity = 2'd1;
    exp_q.push_back(model_frame(8'h55, 4, 1, 1'b0, 1'b0));
    push_word(8'h55, stall);
    wait_idle("t2_odd");

    // Fill the FIFO: 0x01 starts at once, 0x02..0x05 fill it, 0x06 stalls until the next pop.
    cfg_parity = 2'd0;
    for (int i = 1; i <= 6; i++) exp_q.push_back(model_frame(8'(i), 4, 0, 1'b0, i > 1));
    for (int i = 1; i <= 5; i++) push_word(8'(i), stall);
    check("t3_rdy_full", o_rdy, 32'd0);
    check("t3_level_full", o_level, 32'd4);
    push_word(8'h06, stall);
    check("t3_stalled", stall >= 20, 32'd1);
    wait_idle("t3");

    // div 0 -> 2 with two stop bits; divisor change mid-frame only affects the next frame.
    cfg_div   = 16'd0;
    cfg_stop2 = 1'b1;
    exp_q.push_back(model_frame(8'hA3, 0, 0, 1'b1, 1'b0));
    exp_q.push_back(model_frame(8'h5C, 3, 0, 1'b1, 1'b1));
    push_word(8'hA3, stall);
    push_word(8'h5C, stall);
    cfg_div = 16'd3;
    wait_idle("t4");

    // Random bursts with random configuration held per burst.
    for (int r = 0; r < 8; r++) begin
      div   = $urandom_range(0, 5);
      par   = $urandom_range(0, 3);
      stop2 = 1'($urandom_range(0, 1));
      nw    = $urandom_range(1, 3);
      cfg_div    = 16'(div);
      cfg_parity = 2'(par);
      cfg_stop2  = stop2;
      for (int k = 0; k < nw; k++) begin
        w = 8'($urandom);
        exp_q.push_back(model_frame(w, div, par, stop2, k > 0));
        push_word(w, stall);
      end
      wait_idle($sformatf("rnd%0d", r));
    end

    // Reset in data bit 3 with three words queued: the line returns high and nothing else is sent.
    cfg_div    = 16'd4;
    cfg_parity = 2'd0;
    cfg_stop2  = 1'b0;
    exp_q.push_back(model_frame(8'hFF, 4, 0, 1'b0, 1'b0));
    push_word(8'hFF, stall);
    push_word(8'h11, stall);
    push_word(8'h22, stall);
    push_word(8'h33, stall);
    n = 0;
    while (!mon_busy && n < 100) begin @(negedge clk); n++; end
    repeat (16) @(negedge clk);
    check("t5_level_queued", o_level, 32'd3);
    rst = 1'b1;
    @(negedge clk);
    check("t5_tx_rst", tx, 32'd1);
    check("t5_level_rst", o_level, 32'd0);
    check("t5_busy_rst", o_busy, 32'd0);
    check("t5_rdy_rst", o_rdy, 32'd1);
    rst = 1'b0;
    tx_low = 1'b0;
    repeat (100) begin @(negedge clk); if (tx !== 1'b1) tx_low = 1'b1; end
    check("t5_no_frames", tx_low, 32'd0);
    check("t5_queue_empty", exp_q.size(), 32'd0);

`ifdef UART_TX_BREAK_EN
    // Break raised mid-frame: frame completes, line held low, then at least div idle clocks.
    exp_q.push_back(model_frame(8'hA5, 4, 0, 1'b0, 1'b0));
    push_word(8'hA5, stall);
    n = 0;
    while (!mon_busy && n < 100) begin @(negedge clk); n++; end
    repeat (8) @(negedge clk);
    i_break = 1'b1;
    mon_en  = 1'b0;
    push_word(8'h3C, stall);
    repeat (40) @(negedge clk);
    check("t6_break_low", tx, 32'd0);
    check("t6_held", o_level, 32'd1);
    repeat (9) @(negedge clk);
    i_break = 1'b0;
    n = 0;
    while (tx !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    n = 0;
    while (tx === 1'b1 && n < 200) begin @(negedge clk); n++; end
    check("t6_idle_gap", n >= 4 && n < 200, 32'd1);
    repeat (60) @(negedge clk);
    mon_en = 1'b1;
    check("t6_done", o_busy, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
